// File: rtl/kyber_seed_dispatch.sv
// kyber_seed_dispatch
//
// Purpose: seed sequencer placed after the SHA3-512 (Kyber G) block in KeyGen.
// It captures seed d, launches G, splits the 512-bit digest into rho (low half)
// and sigma (high half), then issues K*K XOF seed requests {rho, j, i} with i
// outer and j inner, followed by 2K PRF seed requests {sigma, N} for N = 0..2K-1.
//
// Optional build macro: KYBER_SEED_TRANSPOSE_EN
//   When defined, xof_seed carries {rho, i, j} so the matrix comes out transposed.
//   The counter order is the same in both builds.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, d_in         run request (sampled in IDLE only) and the seed d
//   sha_M, sha_active   message and one-cycle launch pulse toward SHA3-512
//   sha_finish, sha_Z   completion pulse and digest from SHA3-512 (bit 0 first)
//   xof_valid/ready     XOF seed request handshake, payload xof_seed
//   prf_valid/ready     PRF seed request handshake, payload prf_seed
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the last PRF transfer
module kyber_seed_dispatch #(
  parameter int unsigned K      = 3,
  parameter int unsigned SEED_W = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEED_W-1:0]   d_in,
  output logic [SEED_W-1:0]   sha_M,
  output logic                sha_active,
  input  logic                sha_finish,
  input  logic [2*SEED_W-1:0] sha_Z,
  output logic                xof_valid,
  input  logic                xof_ready,
  output logic [SEED_W+15:0]  xof_seed,
  output logic                prf_valid,
  input  logic                prf_ready,
  output logic [SEED_W+7:0]   prf_seed,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    StIdle,
    StShaReq,
    StWaitG,
    StXof,
    StPrf,
    StDone
  } state_e;

  localparam logic [7:0] KLast = 8'(K - 1);
  localparam logic [7:0] NLast = 8'(2 * K - 1);

  state_e            r_state;
  logic [SEED_W-1:0] r_d;
  logic [SEED_W-1:0] r_rho;
  logic [SEED_W-1:0] r_sigma;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [7:0]        r_n;
  logic              r_sha_active;
  logic              r_xof_valid;
  logic              r_prf_valid;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_d          <= '0;
      r_rho        <= '0;
      r_sigma      <= '0;
      r_i          <= 8'd0;
      r_j          <= 8'd0;
      r_n          <= 8'd0;
      r_sha_active <= 1'b0;
      r_xof_valid  <= 1'b0;
      r_prf_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      r_sha_active <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_d          <= d_in;
            r_sha_active <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= StShaReq;
          end
        end
        StShaReq: begin
          r_state <= StWaitG;
        end
        StWaitG: begin
          if (sha_finish) begin
            r_rho       <= sha_Z[SEED_W-1:0];
            r_sigma     <= sha_Z[2*SEED_W-1:SEED_W];
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_xof_valid <= 1'b1;
            r_state     <= StXof;
          end
        end
        StXof: begin
          if (r_xof_valid && xof_ready) begin
            if (r_j == KLast) begin
              r_j <= 8'd0;
              if (r_i == KLast) begin
                // Last matrix entry: hand over straight to the noise seeds.
                r_i         <= 8'd0;
                r_xof_valid <= 1'b0;
                r_n         <= 8'd0;
                r_prf_valid <= 1'b1;
                r_state     <= StPrf;
              end else begin
                r_i <= r_i + 8'd1;
              end
            end else begin
              r_j <= r_j + 8'd1;
            end
          end
        end
        StPrf: begin
          if (r_prf_valid && prf_ready) begin
            if (r_n == NLast) begin
              r_prf_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_n <= r_n + 8'd1;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign sha_M      = r_d;
  assign sha_active = r_sha_active;
  assign xof_valid  = r_xof_valid;
  assign prf_valid  = r_prf_valid;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef KYBER_SEED_TRANSPOSE_EN
  assign xof_seed = {r_rho, r_i, r_j};
`else
  assign xof_seed = {r_rho, r_j, r_i};
`endif

  assign prf_seed = {r_sigma, r_n};

endmodule

// File: tb/tb_kyber_seed_dispatch.sv
// Self-checking bench for kyber_seed_dispatch (K=3 main instance, plus K=2 and
// K=4 instances exercised with ready tied high). Honours KYBER_SEED_TRANSPOSE_EN.
module tb_kyber_seed_dispatch;

  localparam int K = 3;

`ifdef KYBER_SEED_TRANSPOSE_EN
  localparam logic [15:0] SecondKey = 16'h0001;  // (i,j)=(0,1) as {i,j}
  localparam logic [15:0] BpKey     = 16'h0102;  // (i,j)=(1,2) as {i,j}
`else
  localparam logic [15:0] SecondKey = 16'h0100;  // (i,j)=(0,1) as {j,i}
  localparam logic [15:0] BpKey     = 16'h0201;  // (i,j)=(1,2) as {j,i}
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] d_in;
  logic [255:0] sha_M;
  logic         sha_active;
  logic         sha_finish;
  logic [511:0] sha_Z;
  logic         xof_valid;
  logic         xof_ready;
  logic [271:0] xof_seed;
  logic         prf_valid;
  logic         prf_ready;
  logic [263:0] prf_seed;
  logic         busy;
  logic         done;

  kyber_seed_dispatch #(.K(K), .SEED_W(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .d_in       (d_in),
    .sha_M      (sha_M),
    .sha_active (sha_active),
    .sha_finish (sha_finish),
    .sha_Z      (sha_Z),
    .xof_valid  (xof_valid),
    .xof_ready  (xof_ready),
    .xof_seed   (xof_seed),
    .prf_valid  (prf_valid),
    .prf_ready  (prf_ready),
    .prf_seed   (prf_seed),
    .busy       (busy),
    .done       (done)
  );

  // Auxiliary instances for the other ranks.
  logic         aux_start;
  logic         aux_finish;
  logic [511:0] aux_z;
  logic [255:0] a2_m, a4_m;
  logic         a2_act, a4_act, a2_xv, a4_xv, a2_pv, a4_pv;
  logic         a2_busy, a4_busy, a2_done, a4_done;
  logic [271:0] a2_xs, a4_xs;
  logic [263:0] a2_ps, a4_ps;

  kyber_seed_dispatch #(.K(2), .SEED_W(256)) dut_k2 (
    .clk        (clk),
    .rst        (rst),
    .start      (aux_start),
    .d_in       (d_in),
    .sha_M      (a2_m),
    .sha_active (a2_act),
    .sha_finish (aux_finish),
    .sha_Z      (aux_z),
    .xof_valid  (a2_xv),
    .xof_ready  (1'b1),
    .xof_seed   (a2_xs),
    .prf_valid  (a2_pv),
    .prf_ready  (1'b1),
    .prf_seed   (a2_ps),
    .busy       (a2_busy),
    .done       (a2_done)
  );

  kyber_seed_dispatch #(.K(4), .SEED_W(256)) dut_k4 (
    .clk        (clk),
    .rst        (rst),
    .start      (aux_start),
    .d_in       (d_in),
    .sha_M      (a4_m),
    .sha_active (a4_act),
    .sha_finish (aux_finish),
    .sha_Z      (aux_z),
    .xof_valid  (a4_xv),
    .xof_ready  (1'b1),
    .xof_seed   (a4_xs),
    .prf_valid  (a4_pv),
    .prf_ready  (1'b1),
    .prf_seed   (a4_ps),
    .busy       (a4_busy),
    .done       (a4_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (K=3 instance) ----------------
  // A run is a list of expected XOF seeds followed by a list of PRF seeds;
  // the head of the active list is what the DUT must be presenting.
  bit           m_run, m_req, m_wait, m_done;
  logic [255:0] m_d;
  logic [255:0] m_sigma;
  logic [271:0] xq[$];
  logic [263:0] pq[$];
  logic [271:0] xof_log[$];
  logic [263:0] prf_log[$];
  int           n_act, n_done;
  bit           px_hold, pp_hold;
  logic [271:0] px_seed;
  logic [263:0] pp_seed;

  task automatic fill_xq(input logic [511:0] z);
    logic [7:0] a, b;
    m_sigma = z[511:256];
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        a = 8'(i);
        b = 8'(j);
`ifdef KYBER_SEED_TRANSPOSE_EN
        xq.push_back({z[255:0], a, b});
`else
        xq.push_back({z[255:0], b, a});
`endif
      end
    end
  endtask

  task automatic fill_pq();
    logic [7:0] n;
    for (int k = 0; k < 2 * K; k++) begin
      n = 8'(k);
      pq.push_back({m_sigma, n});
    end
  endtask

  always @(negedge clk) begin
    bit old_run, old_wait;
    if (rst) begin
      chk("rst_ctl", {busy, done, sha_active, xof_valid, prf_valid}, '0);
      chk("rst_data", {sha_M, xof_seed[15:0], prf_seed[7:0]}, '0);
      m_run = 0; m_req = 0; m_wait = 0; m_done = 0; m_d = '0; m_sigma = '0;
      xq.delete(); pq.delete();
      px_hold = 0; pp_hold = 0;
    end else begin
      chk("busy", busy, m_run);
      chk("sha_active", sha_active, m_req);
      chk("done", done, m_done);
      chk("sha_M", sha_M, m_d);
      chk("xof_valid", xof_valid, xq.size() > 0);
      chk("prf_valid", prf_valid, pq.size() > 0);
      chk("mutex", xof_valid & prf_valid, 0);
      if (xof_valid && xq.size() > 0) chk("xof_seed", xof_seed, xq[0]);
      if (prf_valid && pq.size() > 0) chk("prf_seed", prf_seed, pq[0]);
      if (px_hold) chk("xof_hold", {xof_valid, xof_seed}, {1'b1, px_seed});
      if (pp_hold) chk("prf_hold", {prf_valid, prf_seed}, {1'b1, pp_seed});
      if (sha_active) n_act++;
      if (done) n_done++;
      if (xof_valid && xof_ready) xof_log.push_back(xof_seed);
      if (prf_valid && prf_ready) prf_log.push_back(prf_seed);
      px_hold = xof_valid && !xof_ready; px_seed = xof_seed;
      pp_hold = prf_valid && !prf_ready; pp_seed = prf_seed;
      // Predict the state after the coming clock edge.
      old_run  = m_run;
      old_wait = m_wait;
      if (m_done) begin m_done = 0; m_run = 0; end
      if (m_req) begin m_req = 0; m_wait = 1; end
      if (!old_run && start) begin m_run = 1; m_req = 1; m_d = d_in; end
      if (xq.size() > 0) begin
        if (xof_ready) begin
          void'(xq.pop_front());
          if (xq.size() == 0) fill_pq();
        end
      end else if (pq.size() > 0) begin
        if (prf_ready) begin
          void'(pq.pop_front());
          if (pq.size() == 0) m_done = 1;
        end
      end
      if (old_wait && sha_finish) begin m_wait = 0; fill_xq(sha_Z); end
    end
  end

  // ---------------- SHA3-512 responder ----------------
  logic [511:0] z_next;
  bit           spur_fin;
  initial begin
    int cnt;
    cnt = 0;
    sha_finish = 1'b0;
    sha_Z = '0;
    forever begin
      @(posedge clk);
      #2;
      sha_finish = 1'b0;
      if (rst) begin
        cnt = 0;
        spur_fin = 0;
      end else begin
        if (sha_active) cnt = $urandom_range(1, 4);
        else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin sha_finish = 1'b1; sha_Z = z_next; end
        end
        if (spur_fin) begin sha_finish = 1'b1; sha_Z = ~z_next; spur_fin = 0; end
      end
    end
  end

  // ---------------- aux instance monitors ----------------
  int           a2_nx, a2_np, a2_nd, a2_na, a4_nx, a4_np, a4_nd, a4_na;
  logic [271:0] a2_lx, a4_lx;
  logic [263:0] a2_lp, a4_lp;
  always @(negedge clk) begin
    if (!rst) begin
      if (a2_xv) begin a2_nx++; a2_lx = a2_xs; end
      if (a2_pv) begin a2_np++; a2_lp = a2_ps; end
      if (a2_done) a2_nd++;
      if (a2_act) a2_na++;
      if (a4_xv) begin a4_nx++; a4_lx = a4_xs; end
      if (a4_pv) begin a4_np++; a4_lp = a4_ps; end
      if (a4_done) a4_nd++;
      if (a4_act) a4_na++;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_rdy, bp_mode, spur_mode, sp_w, sp_p, sp_f;
  int bp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    d_in  = {8{$urandom()}};
    if (rand_rdy) begin
      xof_ready = 1'($urandom_range(0, 1));
      prf_ready = 1'($urandom_range(0, 1));
    end else begin
      xof_ready = 1'b1;
      prf_ready = 1'b1;
    end
    if (bp_mode && xof_valid && xof_seed[15:0] == BpKey && bp_cnt < 5) begin
      xof_ready = 1'b0;
      bp_cnt++;
      chk("bp_seed", xof_seed, {z_next[255:0], BpKey});
    end
    if (spur_mode) begin
      if (busy && !sha_active && !xof_valid && !prf_valid && !done && !sp_w) begin
        start = 1'b1; sp_w = 1;
      end else if (prf_valid && !sp_p) begin
        start = 1'b1; sp_p = 1;
      end
      if (xof_valid && !sp_f) begin spur_fin = 1; sp_f = 1; end
    end
  endtask

  task automatic launch(input logic [255:0] d, input logic [511:0] z);
    d_in   = d;
    z_next = z;
    start  = 1'b1;
    tick();
  endtask

  task automatic run_wait(input string nm);
    int d0;
    d0 = n_done;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (n_done > d0) break;
    end
    chk({nm, "_done_seen"}, n_done - d0, 1);
    tick();
  endtask

  task automatic clear_logs();
    xof_log.delete();
    prf_log.delete();
    n_act = 0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {busy, done, sha_active, xof_valid, prf_valid}, '0);
    chk({nm, "_seeds"}, {xof_seed, prf_seed}, '0);
    chk({nm, "_sha_M"}, sha_M, '0);
  endtask

  function automatic logic [511:0] rnd512();
    return {16{$urandom()}} ^ {$urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [255:0] d_nom;
    logic [511:0] z_nom, z;
    logic [7:0]   n5;
    rst = 1'b1; start = 1'b0; d_in = '0; xof_ready = 1'b1; prf_ready = 1'b1;
    aux_start = 1'b0; aux_finish = 1'b0; aux_z = '0; z_next = '0; spur_fin = 0;
    rand_rdy = 0; bp_mode = 0; spur_mode = 0; bp_cnt = 0;
    n_act = 0; n_done = 0;
    a2_nx = 0; a2_np = 0; a2_nd = 0; a2_na = 0; a4_nx = 0; a4_np = 0; a4_nd = 0; a4_na = 0;
    a2_lx = '0; a4_lx = '0; a2_lp = '0; a4_lp = '0;
    #1;
    check_zero("reset");
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Nominal run: d = bytes 01..20, rho = AA.., sigma = 55..
    for (int b = 0; b < 32; b++) d_nom[255 - 8 * b -: 8] = 8'(b + 1);
    z_nom = {{32{8'h55}}, {32{8'hAA}}};
    clear_logs();
    launch(d_nom, z_nom);
    run_wait("nominal");
    n5 = 8'd5;
    chk("nom_xof_count", xof_log.size(), 9);
    chk("nom_prf_count", prf_log.size(), 6);
    chk("nom_xof_first", xof_log.size() > 0 ? xof_log[0] : '1, {{32{8'hAA}}, 16'h0000});
    chk("nom_xof_second", xof_log.size() > 1 ? xof_log[1] : '1, {{32{8'hAA}}, SecondKey});
    chk("nom_xof_last", xof_log.size() > 8 ? xof_log[8] : '1, {{32{8'hAA}}, 16'h0202});
    chk("nom_prf_first", prf_log.size() > 0 ? prf_log[0] : '1, {{32{8'h55}}, 8'd0});
    chk("nom_prf_last", prf_log.size() > 5 ? prf_log[5] : '1, {{32{8'h55}}, n5});
    chk("nom_act_pulses", n_act, 1);
    chk("nom_sha_M", sha_M, d_nom);

    // Backpressure at (1,2) for five cycles.
    clear_logs();
    bp_mode = 1; bp_cnt = 0;
    launch({8{$urandom()}}, rnd512());
    run_wait("backpressure");
    bp_mode = 0;
    chk("bp_hold_cycles", bp_cnt, 5);
    chk("bp_xof_count", xof_log.size(), 9);
    chk("bp_prf_count", prf_log.size(), 6);

    // Spurious start in WAIT_G/PRF and sha_finish in XOF, random readies.
    clear_logs();
    rand_rdy = 1; spur_mode = 1; sp_w = 0; sp_p = 0; sp_f = 0;
    z = rnd512();
    launch({8{$urandom()}}, z);
    run_wait("spurious");
    spur_mode = 0;
    chk("spur_injected", {sp_w, sp_p, sp_f}, 3'b111);
    chk("spur_prf_last", prf_log.size() > 5 ? prf_log[5] : '1, {z[511:256], n5});
    chk("spur_xof_last", xof_log.size() > 8 ? xof_log[8] : '1, {z[255:0], 16'h0202});
    chk("spur_act_pulses", n_act, 1);

    // Reset after four XOF transfers, then a clean restart.
    rand_rdy = 0;
    clear_logs();
    launch({8{$urandom()}}, rnd512());
    for (int c = 0; c < 100; c++) begin
      tick();
      if (xof_log.size() >= 4) break;
    end
    chk("midrst_progress", xof_log.size(), 4);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_logs();
    z = rnd512();
    launch({8{$urandom()}}, z);
    run_wait("restart");
    chk("restart_first", xof_log.size() > 0 ? xof_log[0] : '1, {z[255:0], 16'h0000});
    chk("restart_xof_count", xof_log.size(), 9);
    chk("restart_act_pulses", n_act, 1);

    // Random runs with random readies.
    rand_rdy = 1;
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      launch({8{$urandom()}}, rnd512());
      run_wait("random");
      chk("rand_counts", {xof_log.size(), prf_log.size()}, {32'd9, 32'd6});
    end
    rand_rdy = 0;

    // K=2 and K=4 instances, ready tied high.
    aux_z = rnd512();
    d_in = {8{$urandom()}};
    aux_start = 1'b1;
    begin
      logic [255:0] d_aux;
      d_aux = d_in;
      tick();
      aux_start = 1'b0;
      tick();
      aux_finish = 1'b1;
      tick();
      aux_finish = 1'b0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (a2_nd > 0 && a4_nd > 0) break;
      end
      chk("k2_sha_M", a2_m, d_aux);
      chk("k4_sha_M", a4_m, d_aux);
    end
    chk("k2_counts", {a2_nx, a2_np, a2_nd, a2_na}, {32'd4, 32'd4, 32'd1, 32'd1});
    chk("k4_counts", {a4_nx, a4_np, a4_nd, a4_na}, {32'd16, 32'd8, 32'd1, 32'd1});
    chk("k2_last_xof", a2_lx, {aux_z[255:0], 16'h0101});
    chk("k4_last_xof", a4_lx, {aux_z[255:0], 16'h0303});
    chk("k2_last_prf", a2_lp, {aux_z[511:256], 8'd3});
    chk("k4_last_prf", a4_lp, {aux_z[511:256], 8'd7});
    chk("aux_idle", {a2_busy, a4_busy}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
